systolic_tile_sequencer: RTL
============================

SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning array rows/cols and number of weight vectors.
REQ-002 SHALL have parameter PE_DATA_WIDTH, default 16, meaning bits per lane.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, meaning memory word address width.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4, meaning idle cycles between weight load and data streaming.
REQ-005 SHALL have parameter VEC_CNT_WIDTH, default 8, meaning width of the vector count.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch job, sampled in IDLE only.
- abort  in  1  cancel job.
- base_addr  in  ADDR_WIDTH  address of weight vector 0.
- num_vectors  in  VEC_CNT_WIDTH  data vectors to stream.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rdata  in  PE_DATA_WIDTH*DEPTH  read data.
- mem_rvalid  in  1  read data valid.
- arr_control  out  1  array weight-load mode.
- arr_wt  out  PE_DATA_WIDTH*DEPTH  weights to array.
- arr_data  out  PE_DATA_WIDTH*DEPTH  data to array.
- arr_valid  out  1  arr_data valid this cycle.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL use states IDLE, LOAD_WEIGHTS, DRAIN, PROCESS, FLUSH, DONE.
REQ-008 IDLE->LOAD_WEIGHTS on start; base_addr and num_vectors SHALL be latched that cycle; start outside IDLE SHALL be ignored.
REQ-009 Memory protocol SHALL allow at most one outstanding request: mem_req is high for exactly one cycle, then held low until mem_rvalid; response latency is arbitrary and at least 1 cycle.
REQ-010 LOAD_WEIGHTS SHALL read addresses base_addr..base_addr+DEPTH-1. Each mem_rvalid SHALL drive arr_wt=mem_rdata and arr_control=1 in the following cycle. The weight register SHALL hold the last vector.
REQ-011 After the DEPTH-th weight response the FSM SHALL enter DRAIN. DRAIN SHALL last exactly DRAIN_CYCLES cycles with arr_control=0 and no mem_req.
REQ-012 PROCESS SHALL read num_vectors words starting at base_addr+DEPTH. Each mem_rvalid SHALL drive arr_data=mem_rdata and arr_valid=1 for one cycle in the following cycle. arr_wt SHALL hold the latched weights.
REQ-013 num_vectors=0 SHALL skip PROCESS: DRAIN goes directly to FLUSH.
REQ-014 FLUSH SHALL last 2*DEPTH-1 cycles with arr_valid=0, then go to DONE. DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-015 Addresses SHALL wrap modulo 2^ADDR_WIDTH.
REQ-016 abort in any non-IDLE state SHALL force IDLE next cycle with no done pulse. An in-flight response arriving later SHALL be dropped. abort has priority over all other transitions.
REQ-017 mem_rvalid with no outstanding request SHALL be ignored.
REQ-018 arr_valid and arr_control SHALL never be high in the same cycle.

Reset
REQ-019 On reset the state SHALL be IDLE and mem_req, arr_control, arr_valid, busy and done SHALL be 0. mem_addr, arr_wt, arr_data and all counters SHALL be 0.
REQ-020 Reset mid-job SHALL take effect at the next edge, discard the job and any outstanding request, and produce no done pulse.

Configuration
REQ-021 Macro SYSTOLIC_SEQ_PERF_CNT_EN, when defined, SHALL add output perf_cycles (32 bits). It counts cycles from start acceptance to done, inclusive, saturates at all-ones, holds its value after done, and clears on reset and on the next start.
REQ-022 Without SYSTOLIC_SEQ_PERF_CNT_EN the port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-023 Default parameters, base_addr=0, num_vectors=3, 1-cycle memory latency -> weight addresses 0..3, data addresses 4..6, 3 arr_valid pulses, exactly 4 DRAIN cycles, 7 FLUSH cycles, one done pulse.
REQ-024 Random memory latency 1..5 -> never two outstanding requests, and arr_data order matches address order.
REQ-025 base_addr=62, num_vectors=2 -> address sequence 62,63,0,1,2,3 (weights 62,63,0,1; data 2,3).
REQ-026 num_vectors=0 -> no arr_valid, FLUSH entered directly after DRAIN, done asserted.
REQ-027 abort during PROCESS with a request in flight -> IDLE next cycle, late rvalid ignored, no done; a following start completes normally.
REQ-028 SYSTOLIC_SEQ_PERF_CNT_EN defined with the REQ-023 stimulus -> perf_cycles equals the measured start-to-done cycle count; start asserted while busy is ignored.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// Sequencer that loads DEPTH weight vectors into a systolic tile, drains, streams data vectors and flushes.
// Optional `SYSTOLIC_SEQ_PERF_CNT_EN adds a saturating start-to-done cycle counter on perf_cycles.
module systolic_tile_sequencer #(
    parameter int DEPTH         = 4,
    parameter int PE_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH    = 6,
    parameter int DRAIN_CYCLES  = 4,
    parameter int VEC_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [VEC_CNT_WIDTH-1:0]       num_vectors,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0] mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           arr_control,
    output logic [PE_DATA_WIDTH*DEPTH-1:0] arr_wt,
    output logic [PE_DATA_WIDTH*DEPTH-1:0] arr_data,
    output logic                           arr_valid,
    output logic                           busy,
    output logic                           done
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_cycles
`endif
);

    localparam int VEC_W        = PE_DATA_WIDTH * DEPTH;
    localparam int CNT_W        = (VEC_CNT_WIDTH > $clog2(DEPTH + 1)) ? VEC_CNT_WIDTH : $clog2(DEPTH + 1);
    localparam int FLUSH_CYCLES = 2 * DEPTH - 1;
    localparam int TMR_MAX      = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int TMR_W        = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WEIGHTS,
        DRAIN,
        PROCESS,
        FLUSH,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [VEC_CNT_WIDTH-1:0] nvec_q, nvec_d;
    logic [CNT_W-1:0]         rsp_cnt_q, rsp_cnt_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic                     outst_q, outst_d;
    logic [VEC_W-1:0]         wt_q, wt_d;
    logic [VEC_W-1:0]         data_q, data_d;
    logic                     ctrl_q, ctrl_d;
    logic                     valid_q, valid_d;
    logic                     rsp_ok;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nvec_d    = nvec_q;
        rsp_cnt_d = rsp_cnt_q;
        tmr_d     = tmr_q;
        outst_d   = outst_q;
        wt_d      = wt_q;
        data_d    = data_q;
        ctrl_d    = 1'b0;
        valid_d   = 1'b0;
        mem_req   = 1'b0;
        rsp_ok    = mem_rvalid && outst_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_WEIGHTS;
                    addr_d    = base_addr;
                    nvec_d    = num_vectors;
                    rsp_cnt_d = '0;
                    tmr_d     = '0;
                    outst_d   = 1'b0;
                end
            end
            // The cycle after the last weight response still belongs here so its arr_control pulse
            // never lands in DRAIN.
            LOAD_WEIGHTS: begin
                if (rsp_cnt_q == DEPTH_C) begin
                    state_d   = DRAIN;
                    rsp_cnt_d = '0;
                    tmr_d     = '0;
                end else if (rsp_ok) begin
                    wt_d      = mem_rdata;
                    ctrl_d    = 1'b1;
                    outst_d   = 1'b0;
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                end else if (!outst_q) begin
                    mem_req = 1'b1;
                    outst_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (tmr_q == DRAIN_LAST) begin
                    tmr_d   = '0;
                    state_d = (nvec_q == '0) ? FLUSH : PROCESS;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            PROCESS: begin
                if (rsp_cnt_q == CNT_W'(nvec_q)) begin
                    state_d   = FLUSH;
                    rsp_cnt_d = '0;
                    tmr_d     = '0;
                end else if (rsp_ok) begin
                    data_d    = mem_rdata;
                    valid_d   = 1'b1;
                    outst_d   = 1'b0;
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                end else if (!outst_q) begin
                    mem_req = 1'b1;
                    outst_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            FLUSH: begin
                if (tmr_q == FLUSH_LAST) begin
                    state_d = DONE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything; clearing the outstanding flag drops any late response.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            outst_d   = 1'b0;
            ctrl_d    = 1'b0;
            valid_d   = 1'b0;
            wt_d      = wt_q;
            data_d    = data_q;
            rsp_cnt_d = '0;
            tmr_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            nvec_q    <= '0;
            rsp_cnt_q <= '0;
            tmr_q     <= '0;
            outst_q   <= 1'b0;
            wt_q      <= '0;
            data_q    <= '0;
            ctrl_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nvec_q    <= nvec_d;
            rsp_cnt_q <= rsp_cnt_d;
            tmr_q     <= tmr_d;
            outst_q   <= outst_d;
            wt_q      <= wt_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
        end
    end

    assign mem_addr    = addr_q;
    assign arr_control = ctrl_q;
    assign arr_wt      = wt_q;
    assign arr_data    = data_q;
    assign arr_valid   = valid_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    // The accepting IDLE cycle counts as 1; every non-IDLE cycle through DONE adds one.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                perf_q <= 32'd1;
            end
        end else if (perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
